i2c_master_burst: RTL and testbench
===================================

// Module: i2c_master_burst
// PURPOSE
//  Parametrised I2C master: one START, 7-bit address + R/W, then 0..2^NB_W-1 data bytes, then STOP.
//  Write bytes are fetched per byte through a tx_data/tx_ready handshake; read bytes are returned as rx_data/rx_valid pulses.
//  Lines are open-drain (drive-low enables only), with SCL clock-stretch support and ACK checking.
//  Sits between a register/CPU front end and the board I2C pads.
// PARAMETERS
//  CLK_DIV  4  sys_clk cycles per SCL quarter-period (>=2); one bit = 4*CLK_DIV cycles
//  NB_W     4  width of nbytes; max burst 2^NB_W-1 bytes
// PORTS
//  sys_clk   in   1     sole clock; all logic on posedge
//  rst       in   1     synchronous, active-high reset
//  start     in   1     1-cycle request; sampled only while busy=0
//  addr      in   7     target address, latched on accepted start
//  rw        in   1     0=write, 1=read, latched on accepted start
//  nbytes    in   NB_W  byte count, latched on accepted start; 0 = address-only probe
//  tx_data   in   8     next write byte; must be valid when tx_ready pulses
//  tx_ready  out  1     1-cycle pulse: tx_data sampled into shift register
//  rx_data   out  8     last received byte
//  rx_valid  out  1     1-cycle pulse: rx_data updated
//  busy      out  1     high from the cycle after start is accepted until done
//  done      out  1     1-cycle pulse at the end of STOP
//  nack      out  1     set when the slave NACKs; cleared on the next accepted start
//  scl_oe    out  1     1 = pull SCL low; 0 = release
//  scl_i     in   1     sampled SCL pad, used for stretch detection
//  sda_oe    out  1     1 = pull SDA low; 0 = release
//  sda_i     in   1     sampled SDA pad
// BEHAVIOUR
//  Reset: all outputs 0 (both lines released), FSM=IDLE, divider and counters 0; rst mid-transfer aborts with no STOP issued.
//  Quarter tick: fires every CLK_DIV cycles while busy. Each bit is Q0..Q3:
//   - Q0: SCL low, SDA updated
//   - Q1: SCL low
//   - Q2: SCL released; tick held (stretch) while scl_i=0
//   - Q3: SCL high; sda_i sampled on entry to Q3
//  FSM states: IDLE, START, ADDR, ACK_A, WR, ACK_W, RD, ACK_R, STOP.
//   - IDLE->START on start. START: both released Q0-Q1, SDA low Q2, SCL low Q3.
//   - ADDR: 8 bits MSB-first, {addr,rw}. ACK_A: SDA released, sample ACK.
//   - ACK_A: NACK -> nack=1, STOP. nbytes=0 -> STOP. rw=0 -> WR with tx_ready pulse. rw=1 -> RD.
//   - WR: 8 bits MSB-first. ACK_W: NACK -> nack=1, STOP (remaining bytes dropped, no further tx_ready).
//   - ACK_W otherwise: more bytes -> WR with tx_ready pulse; else STOP.
//   - RD: SDA released, 8 bits shifted MSB-first; rx_valid pulses the cycle after the 8th sample.
//   - ACK_R: master drives ACK (SDA low) if bytes remain, NACK (released) on the last byte; then RD or STOP.
//   - STOP: SDA low Q0-Q1, SCL released Q1, SDA released Q3; then done pulse, busy=0, IDLE.
//  Byte counter: NB_W bits, loaded from nbytes, decremented per data byte; never wraps.
//  start while busy=1 is ignored (no latch, no effect on nack).
//  Unstretched busy duration = (2 + 9*(nbytes+1)) * 4*CLK_DIV cycles; stretch adds exactly the held cycles.
//  SDA changes only while SCL is low, except the START/STOP edges.
// TESTING
//  Write, CLK_DIV=4, addr=0x50, nbytes=2, tx 0xA5,0x3C, slave ACKs all:
//   -> SDA bit stream 0xA0,0xA5,0x3C; 2 tx_ready pulses; busy high 464 cycles; done=1, nack=0.
//  Read, addr=0x51, nbytes=3, slave returns 0x11,0x22,0x33:
//   -> 3 rx_valid pulses with those values; master ACK,ACK,NACK; then STOP.
//  Address NACK (slave never pulls SDA):
//   -> nack=1, STOP right after ACK_A, no tx_ready; busy 176 cycles.
//  Stretch: scl_i held low 50 cycles during the Q2 of bit 3 -> busy extends by 50; data unchanged.
//  Mid-write rst at cycle 200 -> next cycle all outputs 0, FSM=IDLE; a new start runs a normal transfer.
//  start pulsed while busy, then nbytes=0 probe -> first transfer unaffected; probe gives ADDR+ACK+STOP only.

Source files
------------

// File: rtl/i2c_master_burst.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_burst
//  Purpose  : Open-drain I2C master issuing START, address+R/W, a burst of
//             0..2^NB_W-1 data bytes and STOP, with clock-stretch support.
//  Revision : 1.0
// ============================================================================
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int NB_W    = 4
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            start,
    input  logic [6:0]      addr,
    input  logic            rw,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      tx_data,
    output logic            tx_ready,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            done,
    output logic            nack,
    output logic            scl_oe,
    input  logic            scl_i,
    output logic            sda_oe,
    input  logic            sda_i
);

    localparam int c_DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK_A = 4'd3,
        S_WR    = 4'd4,
        S_ACK_W = 4'd5,
        S_RD    = 4'd6,
        S_ACK_R = 4'd7,
        S_STOP  = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]        r_q;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [NB_W-1:0]   r_cnt;
    logic              r_rw;
    logic              r_smp;
    logic              r_nack;
    logic              r_done;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;

    logic w_hold;
    logic w_tick;
    logic w_bit_end;
    logic w_sample;
    logic w_accept;
    logic w_load_tx;
    logic w_shift;
    logic w_dec;
    logic w_set_nack;
    logic w_done;

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign nack     = r_nack;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // The quarter timer freezes in Q2 while a slave holds SCL low.
    assign w_hold    = (r_q == 2'd2) && !scl_i;
    assign w_tick    = busy && !w_hold && (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_bit_end = w_tick && (r_q == 2'd3);
    assign w_sample  = w_tick && (r_q == 2'd2);
    assign w_accept  = (r_state == S_IDLE) && start;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_tx   = 1'b0;
        w_shift     = 1'b0;
        w_dec       = 1'b0;
        w_set_nack  = 1'b0;
        w_done      = 1'b0;
        scl_oe      = 1'b0;
        sda_oe      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_START;
            end
            S_START: begin
                scl_oe = (r_q == 2'd3);
                sda_oe = r_q[1];
                if (w_bit_end) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                scl_oe = !r_q[1];
                sda_oe = !r_shift[7];
                if (w_bit_end) begin
                    if (r_bit == 3'd7) w_state_nxt = S_ACK_A;
                    else               w_shift     = 1'b1;
                end
            end
            S_ACK_A: begin
                scl_oe = !r_q[1];
                if (w_bit_end) begin
                    if (r_smp) begin
                        w_set_nack  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_STOP;
                    end else if (!r_rw) begin
                        w_load_tx   = 1'b1;
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_WR: begin
                scl_oe = !r_q[1];
                sda_oe = !r_shift[7];
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_dec       = 1'b1;
                        w_state_nxt = S_ACK_W;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_ACK_W: begin
                scl_oe = !r_q[1];
                if (w_bit_end) begin
                    if (r_smp) begin
                        w_set_nack  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else if (r_cnt != '0) begin
                        w_load_tx   = 1'b1;
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_RD: begin
                scl_oe = !r_q[1];
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_dec       = 1'b1;
                    w_state_nxt = S_ACK_R;
                end
            end
            S_ACK_R: begin
                // Counter is already decremented here: zero means last byte, so NACK.
                scl_oe = !r_q[1];
                sda_oe = (r_cnt != '0);
                if (w_bit_end) begin
                    if (r_cnt != '0) w_state_nxt = S_RD;
                    else             w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                scl_oe = (r_q == 2'd0);
                sda_oe = (r_q != 2'd3);
                if (w_bit_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        tx_ready = w_load_tx;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_smp      <= 1'b0;
            r_nack     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
        end else begin
            r_done     <= w_done;
            r_rx_valid <= 1'b0;

            if (!busy || w_tick) r_div <= '0;
            else if (!w_hold)    r_div <= r_div + c_DIV_W'(1);

            if (!busy)       r_q <= 2'd0;
            else if (w_tick) r_q <= r_q + 2'd1;

            if (w_accept) begin
                r_shift <= {addr, rw};
                r_rw    <= rw;
                r_cnt   <= nbytes;
                r_nack  <= 1'b0;
                r_bit   <= 3'd0;
            end

            if (w_sample) begin
                r_smp <= sda_i;
                if (r_state == S_RD) begin
                    r_shift <= {r_shift[6:0], sda_i};
                    if (r_bit == 3'd7) begin
                        r_rx_data  <= {r_shift[6:0], sda_i};
                        r_rx_valid <= 1'b1;
                    end
                end
            end

            if (w_shift)   r_shift <= {r_shift[6:0], 1'b0};
            if (w_load_tx) r_shift <= tx_data;

            if (w_bit_end && ((r_state == S_ADDR) || (r_state == S_WR) || (r_state == S_RD)))
                r_bit <= r_bit + 3'd1;

            if (w_dec && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
            if (w_set_nack)             r_nack <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_burst
//  Purpose  : Directed bench for i2c_master_burst with a bus-level slave model.
//  Revision : 1.0
// ============================================================================
module tb_i2c_master_burst;

    localparam int CLK_DIV = 4;
    localparam int NB_W    = 4;

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b1;
    logic            start   = 1'b0;
    logic [6:0]      addr    = 7'd0;
    logic            rw      = 1'b0;
    logic [NB_W-1:0] nbytes  = '0;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            busy;
    logic            done;
    logic            nack;
    logic            scl_oe;
    logic            scl_i;
    logic            sda_oe;
    logic            sda_i;

    logic stretch    = 1'b0;
    logic slave_pull = 1'b0;

    assign scl_i = ~(scl_oe | stretch);
    assign sda_i = ~(sda_oe | slave_pull);

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .NB_W(NB_W)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .nbytes  (nbytes),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .done    (done),
        .nack    (nack),
        .scl_oe  (scl_oe),
        .scl_i   (scl_i),
        .sda_oe  (sda_oe),
        .sda_i   (sda_i)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Slave configuration, written by the test tasks only.
    logic       slv_ack_addr = 1'b1;
    int         slv_nbytes   = 0;
    logic [7:0] slv_rd [0:15];
    int         stretch_bit  = -1;
    int         stretch_len  = 0;
    logic [7:0] tx_mem [0:255];

    // Monitor state, written by the monitor process only.
    logic scl_prev     = 1'b1;
    logic sda_prev     = 1'b1;
    logic bit_mem [0:127];
    int   bit_cnt      = 0;
    int   busy_cnt     = 0;
    int   done_cnt     = 0;
    int   stop_cnt     = 0;
    int   tx_cnt       = 0;
    int   tx_idx       = 0;
    logic tx_seen      = 1'b0;
    int   rx_cnt       = 0;
    logic [7:0] rx_mem [0:31];
    int   stretch_left = 0;
    int   k, j, b;
    logic pull;

    assign tx_data = tx_mem[tx_idx[7:0]];

    always @(negedge sys_clk) begin
        scl_prev <= scl_i;
        sda_prev <= sda_i;
        tx_seen  <= tx_ready;
        if (tx_seen)  tx_idx   <= tx_idx + 1;
        if (tx_ready) tx_cnt   <= tx_cnt + 1;
        if (busy)     busy_cnt <= busy_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
        if (rx_valid) begin
            rx_mem[rx_cnt % 32] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (rst) begin
            slave_pull <= 1'b0;
            stretch    <= 1'b0;
        end else if (scl_prev && scl_i && sda_prev && !sda_i) begin
            bit_cnt <= 0;
        end else if (scl_prev && scl_i && !sda_prev && sda_i) begin
            stop_cnt <= stop_cnt + 1;
        end else if (!scl_prev && scl_i) begin
            bit_mem[bit_cnt % 128] <= sda_i;
            bit_cnt <= bit_cnt + 1;
        end else if (scl_prev && !scl_i) begin
            k    = bit_cnt;
            pull = 1'b0;
            if (k == 8) begin
                pull = slv_ack_addr;
            end else if (k > 8) begin
                j = (k - 9) / 9;
                b = (k - 9) % 9;
                if (j < slv_nbytes) begin
                    if (!bit_mem[7]) pull = (b == 8);
                    else if (b < 8)  pull = !slv_rd[j][7-b];
                end
            end
            slave_pull <= pull;
            if (k == stretch_bit) begin
                stretch      <= 1'b1;
                stretch_left <= stretch_len;
            end
        end
        if (!rst && stretch && !scl_oe) begin
            if (stretch_left == 0) stretch <= 1'b0;
            else                   stretch_left <= stretch_left - 1;
        end
    end

    function automatic logic [7:0] get_byte(input int off);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = bit_mem[off+i];
        return v;
    endfunction

    task automatic launch(input logic [6:0] a, input logic r, input logic [3:0] n);
        @(negedge sys_clk);
        addr   = a;
        rw     = r;
        nbytes = n;
        start  = 1'b1;
        @(negedge sys_clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done: got no pulse within %0d cycles, expected 1", name, n);
        end
        @(negedge sys_clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: got %0b expected 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({scl_oe, sda_oe, busy, done, nack, tx_ready, rx_valid} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected 0000000",
                     {scl_oe, sda_oe, busy, done, nack, tx_ready, rx_valid});
        end
        vectors++;
        if (rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_write;
        int b0 = busy_cnt, t0 = tx_cnt, s0 = stop_cnt;
        tx_mem[tx_cnt % 256]       = 8'hA5;
        tx_mem[(tx_cnt + 1) % 256] = 8'h3C;
        slv_ack_addr = 1'b1;
        slv_nbytes   = 2;
        launch(7'h50, 1'b0, 4'd2);
        wait_done("write");
        vectors++;
        if (get_byte(0) !== 8'hA0) begin miscompares++; $display("FAIL write_addr: got %h expected a0", get_byte(0)); end
        vectors++;
        if (get_byte(9) !== 8'hA5) begin miscompares++; $display("FAIL write_b0: got %h expected a5", get_byte(9)); end
        vectors++;
        if (get_byte(18) !== 8'h3C) begin miscompares++; $display("FAIL write_b1: got %h expected 3c", get_byte(18)); end
        vectors++;
        if (tx_cnt - t0 != 2) begin miscompares++; $display("FAIL write_tx_ready: got %0d expected 2", tx_cnt - t0); end
        vectors++;
        if (busy_cnt - b0 != 464) begin miscompares++; $display("FAIL write_busy: got %0d expected 464", busy_cnt - b0); end
        vectors++;
        if (nack !== 1'b0) begin miscompares++; $display("FAIL write_nack: got %b expected 0", nack); end
        vectors++;
        if (stop_cnt - s0 != 1) begin miscompares++; $display("FAIL write_stop: got %0d expected 1", stop_cnt - s0); end
    endtask

    task automatic test_read;
        int b0 = busy_cnt, t0 = tx_cnt, r0 = rx_cnt;
        slv_rd[0] = 8'h11;
        slv_rd[1] = 8'h22;
        slv_rd[2] = 8'h33;
        slv_nbytes = 3;
        launch(7'h51, 1'b1, 4'd3);
        wait_done("read");
        vectors++;
        if (get_byte(0) !== 8'hA3) begin miscompares++; $display("FAIL read_addr: got %h expected a3", get_byte(0)); end
        vectors++;
        if (rx_cnt - r0 != 3) begin miscompares++; $display("FAIL read_rx_valid: got %0d expected 3", rx_cnt - r0); end
        vectors++;
        if (rx_mem[r0 % 32] !== 8'h11) begin miscompares++; $display("FAIL read_b0: got %h expected 11", rx_mem[r0 % 32]); end
        vectors++;
        if (rx_mem[(r0 + 1) % 32] !== 8'h22) begin miscompares++; $display("FAIL read_b1: got %h expected 22", rx_mem[(r0 + 1) % 32]); end
        vectors++;
        if (rx_mem[(r0 + 2) % 32] !== 8'h33) begin miscompares++; $display("FAIL read_b2: got %h expected 33", rx_mem[(r0 + 2) % 32]); end
        vectors++;
        if ({bit_mem[17], bit_mem[26], bit_mem[35]} !== 3'b001) begin
            miscompares++;
            $display("FAIL read_master_ack: got %b expected 001", {bit_mem[17], bit_mem[26], bit_mem[35]});
        end
        vectors++;
        if (busy_cnt - b0 != 608) begin miscompares++; $display("FAIL read_busy: got %0d expected 608", busy_cnt - b0); end
        vectors++;
        if (tx_cnt - t0 != 0) begin miscompares++; $display("FAIL read_tx_ready: got %0d expected 0", tx_cnt - t0); end
    endtask

    task automatic test_addr_nack;
        int b0 = busy_cnt, t0 = tx_cnt, s0 = stop_cnt;
        slv_ack_addr = 1'b0;
        slv_nbytes   = 3;
        launch(7'h2A, 1'b0, 4'd3);
        repeat (165) @(negedge sys_clk);
        addr   = 7'h33;
        rw     = 1'b1;
        nbytes = 4'd4;
        start  = 1'b1;
        @(negedge sys_clk);
        start  = 1'b0;
        wait_done("addr_nack");
        vectors++;
        if (nack !== 1'b1) begin miscompares++; $display("FAIL nack_flag: got %b expected 1", nack); end
        vectors++;
        if (tx_cnt - t0 != 0) begin miscompares++; $display("FAIL nack_tx_ready: got %0d expected 0", tx_cnt - t0); end
        vectors++;
        if (busy_cnt - b0 != 176) begin miscompares++; $display("FAIL nack_busy: got %0d expected 176", busy_cnt - b0); end
        vectors++;
        if (bit_mem[8] !== 1'b1) begin miscompares++; $display("FAIL nack_ack_bit: got %b expected 1", bit_mem[8]); end
        vectors++;
        if (stop_cnt - s0 != 1) begin miscompares++; $display("FAIL nack_stop: got %0d expected 1", stop_cnt - s0); end
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL nack_ignored_start: got busy %b expected 0", busy); end
        slv_ack_addr = 1'b1;
    endtask

    task automatic test_probe;
        int b0 = busy_cnt, t0 = tx_cnt, r0 = rx_cnt;
        slv_nbytes = 0;
        launch(7'h50, 1'b0, 4'd0);
        vectors++;
        if (nack !== 1'b0) begin miscompares++; $display("FAIL probe_nack_clear: got %b expected 0", nack); end
        wait_done("probe");
        vectors++;
        if (busy_cnt - b0 != 176) begin miscompares++; $display("FAIL probe_busy: got %0d expected 176", busy_cnt - b0); end
        vectors++;
        if (bit_cnt != 10) begin miscompares++; $display("FAIL probe_scl_pulses: got %0d expected 10", bit_cnt); end
        vectors++;
        if ({get_byte(0), bit_mem[8]} !== 9'h140) begin
            miscompares++;
            $display("FAIL probe_addr_ack: got %h expected 140", {get_byte(0), bit_mem[8]});
        end
        vectors++;
        if ((tx_cnt - t0) + (rx_cnt - r0) != 0) begin
            miscompares++;
            $display("FAIL probe_data: got %0d expected 0", (tx_cnt - t0) + (rx_cnt - r0));
        end
        vectors++;
        if (nack !== 1'b0) begin miscompares++; $display("FAIL probe_nack: got %b expected 0", nack); end
    endtask

    task automatic test_stretch;
        int b0 = busy_cnt;
        tx_mem[tx_cnt % 256]       = 8'hA5;
        tx_mem[(tx_cnt + 1) % 256] = 8'h3C;
        slv_nbytes  = 2;
        stretch_len = 50;
        stretch_bit = 3;
        launch(7'h50, 1'b0, 4'd2);
        wait_done("stretch");
        stretch_bit = -1;
        vectors++;
        if (busy_cnt - b0 != 514) begin miscompares++; $display("FAIL stretch_busy: got %0d expected 514", busy_cnt - b0); end
        vectors++;
        if ({get_byte(0), get_byte(9), get_byte(18)} !== 24'hA0A53C) begin
            miscompares++;
            $display("FAIL stretch_data: got %h expected a0a53c", {get_byte(0), get_byte(9), get_byte(18)});
        end
    endtask

    task automatic test_reset_mid;
        int b0, d0;
        tx_mem[tx_cnt % 256]       = 8'h12;
        tx_mem[(tx_cnt + 1) % 256] = 8'h34;
        tx_mem[(tx_cnt + 2) % 256] = 8'h56;
        slv_nbytes = 3;
        launch(7'h50, 1'b0, 4'd3);
        repeat (199) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if ({scl_oe, sda_oe, busy, done, nack, tx_ready, rx_valid, rx_data} !== 15'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h expected 0000",
                     {scl_oe, sda_oe, busy, done, nack, tx_ready, rx_valid, rx_data});
        end
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        b0 = busy_cnt;
        d0 = done_cnt;
        tx_mem[tx_cnt % 256] = 8'h96;
        slv_nbytes = 1;
        launch(7'h50, 1'b0, 4'd1);
        wait_done("midrst_retry");
        vectors++;
        if (busy_cnt - b0 != 320) begin miscompares++; $display("FAIL midrst_busy: got %0d expected 320", busy_cnt - b0); end
        vectors++;
        if ({get_byte(0), get_byte(9)} !== 16'hA096) begin
            miscompares++;
            $display("FAIL midrst_data: got %h expected a096", {get_byte(0), get_byte(9)});
        end
        vectors++;
        if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL midrst_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        int b0 = busy_cnt, t0 = tx_cnt;
        tx_mem[tx_cnt % 256] = 8'h5A;
        slv_nbytes = 1;
        launch(7'h50, 1'b0, 4'd1);
        repeat (40) @(negedge sys_clk);
        addr   = 7'h11;
        rw     = 1'b1;
        nbytes = 4'd5;
        start  = 1'b1;
        @(negedge sys_clk);
        start  = 1'b0;
        wait_done("b2b");
        vectors++;
        if (busy_cnt - b0 != 320) begin miscompares++; $display("FAIL b2b_busy: got %0d expected 320", busy_cnt - b0); end
        vectors++;
        if ({get_byte(0), get_byte(9)} !== 16'hA05A) begin
            miscompares++;
            $display("FAIL b2b_data: got %h expected a05a", {get_byte(0), get_byte(9)});
        end
        vectors++;
        if (tx_cnt - t0 != 1) begin miscompares++; $display("FAIL b2b_tx_ready: got %0d expected 1", tx_cnt - t0); end
        test_probe();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_probe();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
